ddr_port_arbiter: RTL and testbench



---
 rtl/ddr_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// Two-port arbiter serialising single-word transactions onto the DDR controller port.
// Optional pause-stuck watchdog is compiled in with `define DDR_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; winner chosen and its command latched on grant
// ISSUE | latched command loaded onto the ddr_* outputs, strobe raised
// HOLD  | one cycle for the controller to raise pause; pause ignored
// WAIT  | waiting for pause to fall (or the watchdog to expire)
// DONE  | ack (and rdata_valid for reads) visible to the owning port

module ddr_port_arbiter #(
`ifdef DDR_ARB_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 4096,
`endif
   parameter int CAM_BURST_MAX  = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        write0,
   input  logic        write1,
   input  logic [19:0] addr0,
   input  logic [19:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic [19:0] ddr_addr,
   output logic [31:0] ddr_data_write,
   output logic        ddr_wren,
   output logic        ddr_cmd_strobe,
   input  logic [31:0] data_read,
   input  logic        pause,
   output logic        grant_owner,
   output logic        arb_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_HOLD,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_CAM_MAX = 4'(CAM_BURST_MAX);

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_owner;
   logic        r_last_grant;
   logic [3:0]  r_cam_run;
   logic        r_write;
   logic [19:0] r_addr;
   logic [31:0] r_wdata;

   logic        r_ack0;
   logic        r_ack1;
   logic [31:0] r_rdata;
   logic        r_rdata_valid;
   logic [19:0] r_ddr_addr;
   logic [31:0] r_ddr_wdata;
   logic        r_ddr_wren;
   logic        r_cmd_strobe;

   logic        w_any_req;
   logic        w_pick1;
   logic        w_grant;
   logic        w_complete;
   logic        w_timeout;

   assign w_any_req  = req0 | req1;
   // Tie: round-robin, except port 0 keeps winning until its run hits the burst cap.
   assign w_pick1    = req1 & (~req0 | (~r_last_grant & (r_cam_run >= LP_CAM_MAX)));
   assign w_grant    = (r_state == S_IDLE) & w_any_req;
   assign w_complete = (r_state == S_WAIT) & ~pause;

`ifdef DDR_ARB_TIMEOUT_EN
   logic [15:0] r_to_cnt;
   logic        r_arb_timeout;

   assign w_timeout = (r_state == S_WAIT) & pause & (r_to_cnt == 16'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_to_cnt      <= 16'd0;
         r_arb_timeout <= 1'b0;
      end else begin
         if (r_state == S_HOLD)
            r_to_cnt <= 16'(TIMEOUT_CYCLES - 1);
         else if ((r_state == S_WAIT) && (r_to_cnt != 16'd0))
            r_to_cnt <= r_to_cnt - 16'd1;
         if (w_timeout)
            r_arb_timeout <= 1'b1;
      end
   end

   assign arb_timeout = r_arb_timeout;
`else
   assign w_timeout   = 1'b0;
   assign arb_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_HOLD;
         S_HOLD:  w_state_nxt = S_WAIT;
         S_WAIT:  if (w_complete | w_timeout) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_owner       <= 1'b0;
         r_last_grant  <= 1'b1;
         r_cam_run     <= 4'd0;
         r_write       <= 1'b0;
         r_addr        <= 20'd0;
         r_wdata       <= 32'd0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_rdata       <= 32'd0;
         r_rdata_valid <= 1'b0;
         r_ddr_addr    <= 20'd0;
         r_ddr_wdata   <= 32'd0;
         r_ddr_wren    <= 1'b0;
         r_cmd_strobe  <= 1'b0;
      end else begin
         r_cmd_strobe  <= 1'b0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_rdata_valid <= 1'b0;

         if (w_grant) begin
            r_owner      <= w_pick1;
            r_last_grant <= w_pick1;
            r_write      <= w_pick1 ? write1 : write0;
            r_addr       <= w_pick1 ? addr1  : addr0;
            r_wdata      <= w_pick1 ? wdata1 : wdata0;
            // Saturate so a long solo camera run cannot wrap and re-arm the override.
            if (w_pick1)
               r_cam_run <= 4'd0;
            else if (r_cam_run < LP_CAM_MAX)
               r_cam_run <= r_cam_run + 4'd1;
         end

         if (r_state == S_ISSUE) begin
            r_ddr_addr   <= r_addr;
            r_ddr_wdata  <= r_wdata;
            r_ddr_wren   <= r_write;
            r_cmd_strobe <= 1'b1;
         end

         if (w_complete | w_timeout) begin
            r_ack0 <= ~r_owner;
            r_ack1 <= r_owner;
         end

         if (w_complete & ~r_write) begin
            r_rdata       <= data_read;
            r_rdata_valid <= 1'b1;
         end
      end
   end

   assign ack0           = r_ack0;
   assign ack1           = r_ack1;
   assign rdata          = r_rdata;
   assign rdata_valid    = r_rdata_valid;
   assign ddr_addr       = r_ddr_addr;
   assign ddr_data_write = r_ddr_wdata;
   assign ddr_wren       = r_ddr_wren;
   assign ddr_cmd_strobe = r_cmd_strobe;
   assign grant_owner    = r_owner;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: vector table, arbitration sequences, reset abort.
// A behavioural controller model drives pause/data_read; a queue scoreboard checks commands and acks.

module tb_ddr_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        write0 = 1'b0, write1 = 1'b0;
   logic [19:0] addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic [19:0] ddr_addr;
   logic [31:0] ddr_data_write;
   logic        ddr_wren;
   logic        ddr_cmd_strobe;
   logic [31:0] data_read = '0;
   logic        pause = 1'b0;
   logic        grant_owner;
   logic        arb_timeout;

   always #5 clk = ~clk;

   ddr_port_arbiter #(
`ifdef DDR_ARB_TIMEOUT_EN
      .TIMEOUT_CYCLES(16),
`endif
      .CAM_BURST_MAX(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .write0(write0), .write1(write1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .rdata_valid(rdata_valid),
      .ddr_addr(ddr_addr), .ddr_data_write(ddr_data_write), .ddr_wren(ddr_wren),
      .ddr_cmd_strobe(ddr_cmd_strobe), .data_read(data_read), .pause(pause),
      .grant_owner(grant_owner), .arb_timeout(arb_timeout)
   );

   typedef struct {
      bit          port;
      bit          wr;
      logic [19:0] addr;
      logic [31:0] wdata;
      int          pause_n;
      logic [31:0] rd_val;
      bit          to;
   } txn_t;

   txn_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          to_seen = 1'b0;
   logic [31:0] cur_rd = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Controller model and scoreboard: pause held for pause_n WAIT cycles after the strobe.
   initial begin
      int   pc;
      txn_t t;
      pc = 0;
      forever begin
         @(posedge clk); #1;
         if (!reset_n) begin
            pc = 0;
            pause = 1'b0;
         end else begin
            if (pc > 0) begin
               pc--;
               if (pc == 0) begin
                  pause = 1'b0;
                  data_read = cur_rd;
               end
            end
            if (ddr_cmd_strobe) begin
               if (exp_q.size() == 0) chk("strobe_unexpected", 64'(ddr_cmd_strobe), 64'd0);
               else begin
                  chk("cmd_addr", 64'(ddr_addr), 64'(exp_q[0].addr));
                  chk("cmd_wren", 64'(ddr_wren), 64'(exp_q[0].wr));
                  if (exp_q[0].wr) chk("cmd_wdata", 64'(ddr_data_write), 64'(exp_q[0].wdata));
                  pause = (exp_q[0].pause_n > 0);
                  pc = exp_q[0].pause_n + 1;
                  cur_rd = exp_q[0].rd_val;
                  data_read = ~exp_q[0].rd_val;
               end
            end
            if (ack0 | ack1) begin
               if (exp_q.size() == 0) chk("ack_unexpected", 64'({ack1, ack0}), 64'd0);
               else begin
                  t = exp_q.pop_front();
                  chk("ack_port", 64'({ack1, ack0}), t.port ? 64'd2 : 64'd1);
                  chk("grant_owner", 64'(grant_owner), 64'(t.port));
                  chk("ddr_addr_hold", 64'(ddr_addr), 64'(t.addr));
                  if (t.to) to_seen = 1'b1;
                  chk("arb_timeout", 64'(arb_timeout), 64'(to_seen));
                  chk("rdata_valid", 64'(rdata_valid), 64'(!t.wr && !t.to));
                  if (!t.wr && !t.to) chk("rdata", 64'(rdata), 64'(t.rd_val));
                  if (t.to) begin
                     pc = 0;
                     pause = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic drive_fields(input txn_t t);
      if (t.port) begin
         write1 = t.wr; addr1 = t.addr; wdata1 = t.wdata;
      end else begin
         write0 = t.wr; addr0 = t.addr; wdata0 = t.wdata;
      end
   endtask

   task automatic wait_ack(input bit port, output int lat, output int strobe_at);
      lat = -1;
      strobe_at = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (ddr_cmd_strobe && strobe_at < 0) strobe_at = k;
         if (port ? ack1 : ack0) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) chk("ack_wait_timeout", 64'(port ? ack1 : ack0), 64'd1);
   endtask

   task automatic wait_any_ack(output bit p);
      bit got;
      got = 1'b0;
      p = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (ack0 | ack1) begin
            p = ack1;
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("any_ack_timeout", 64'(ack0 | ack1), 64'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ctl"}, 64'({ack0, ack1, rdata_valid, ddr_wren, ddr_cmd_strobe,
                              grant_owner, arb_timeout, ddr_addr}), 64'd0);
      chk({tag, "_data"}, {rdata, ddr_data_write}, 64'd0);
   endtask

   task automatic do_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      reset_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   txn_t vecs[6];
   txn_t e0, e1, junk, t;
   int   lat, sa;
   bit   p;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 20'h00010, 32'hAABB00CC,  0, 32'h00000000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 20'h12C00, 32'h00000000, 10, 32'hDEADBEEF, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 20'h0FFFF, 32'h00000000,  3, 32'h12345678, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 20'hFFFFF, 32'hFFFFFFFF,  1, 32'h00000000, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 20'h00000, 32'h00000000,  0, 32'h00000001, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 20'h4B000, 32'h5A5AA5A5,  2, 32'h00000000, 1'b0};
      e0 = '{1'b0, 1'b1, 20'h00100, 32'h11110000, 0, 32'h00000000, 1'b0};
      e1 = '{1'b1, 1'b0, 20'h00200, 32'h00000000, 1, 32'h22220000, 1'b0};

      #1;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single-port transactions from the table; the other port carries decoy fields.
      for (int i = 0; i < 6; i++) begin
         t = vecs[i];
         junk = '{~t.port, ~t.wr, ~t.addr, ~t.wdata, 0, 32'h0, 1'b0};
         drive_fields(t);
         drive_fields(junk);
         exp_q.push_back(t);
         if (t.port) req1 = 1'b1; else req0 = 1'b1;
         wait_ack(t.port, lat, sa);
         req0 = 1'b0;
         req1 = 1'b0;
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4 + t.pause_n));
         chk($sformatf("vec%0d_strobe_at", i), 64'(sa), 64'd2);
         @(posedge clk); #1;
         if (!t.wr) chk($sformatf("vec%0d_rdata_hold", i), 64'(rdata), 64'(t.rd_val));
      end

      // Ties below the burst cap: port 0 first after reset, override, then round-robin.
      do_reset();
      drive_fields(e0);
      drive_fields(e1);
      exp_q.push_back(e0); exp_q.push_back(e0); exp_q.push_back(e1);
      exp_q.push_back(e0); exp_q.push_back(e1);
      req0 = 1'b1;
      req1 = 1'b1;
      wait_any_ack(p); chk("rr_grant0", 64'(p), 64'd0);
      wait_any_ack(p); chk("rr_grant1", 64'(p), 64'd0);
      req0 = 1'b0;
      wait_any_ack(p); chk("rr_grant2", 64'(p), 64'd1);
      req0 = 1'b1;
      wait_any_ack(p); chk("rr_grant3", 64'(p), 64'd0);
      req0 = 1'b0;
      wait_any_ack(p); chk("rr_grant4", 64'(p), 64'd1);
      req1 = 1'b0;
      @(posedge clk); #1;

      // Both requesting continuously: 8 camera grants, then one engine grant, repeated.
      do_reset();
      drive_fields(e0);
      drive_fields(e1);
      for (int i = 0; i < 18; i++) exp_q.push_back((i % 9 == 8) ? e1 : e0);
      req0 = 1'b1;
      req1 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         wait_any_ack(p);
         chk($sformatf("burst_grant%0d", i), 64'(p), 64'((i % 9) == 8));
         if (i == 17) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      @(posedge clk); #1;
      chk("burst_queue_drained", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in WAIT abandons the transaction; held req0 then completes.
      do_reset();
      t = '{1'b0, 1'b1, 20'h33333, 32'hC0FFEE01, 20, 32'h0, 1'b0};
      drive_fields(t);
      exp_q.push_back(t);
      req0 = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_in_wait", 64'(pause), 64'd1);
      #3;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check_outputs_zero("midrst");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_ack", 64'({ack1, ack0}), 64'd0);
      end
      reset_n = 1'b1;
      t.pause_n = 2;
      t.wdata = 32'hC0FFEE02;
      drive_fields(t);
      exp_q.push_back(t);
      wait_ack(1'b0, lat, sa);
      req0 = 1'b0;
      chk("midrst_retry_latency", 64'(lat), 64'd6);
      @(posedge clk); #1;

`ifdef DDR_ARB_TIMEOUT_EN
      t = '{1'b1, 1'b0, 20'h00042, 32'h0, 1000, 32'h0BADF00D, 1'b1};
      drive_fields(t);
      exp_q.push_back(t);
      req1 = 1'b1;
      wait_ack(1'b1, lat, sa);
      req1 = 1'b0;
      chk("timeout_latency", 64'(lat), 64'd19);
      @(posedge clk); #1;
      t = '{1'b0, 1'b1, 20'h00043, 32'h13579BDF, 0, 32'h0, 1'b0};
      drive_fields(t);
      exp_q.push_back(t);
      req0 = 1'b1;
      wait_ack(1'b0, lat, sa);
      req0 = 1'b0;
      chk("timeout_sticky", 64'(arb_timeout), 64'd1);
`else
      chk("timeout_off", 64'(arb_timeout), 64'd0);
`endif

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
